pulse_sched: RTL and testbench

Timed command scheduler between the processor core (`proc`) and the pulse/function-processor outputs. `proc` pushes (command, trigger-time) pairs into a small FIFO; the block compares the head entry's trigger time against the free-running `qclk` value and releases each command as a one-cycle strobe exactly when its time arrives. Late entries are dropped and flagged. This lets `proc` run ahead of real time while output timing stays deterministic.

---
 rtl/pulse_sched.sv | 86 ++++++++
 tb/tb_pulse_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_sched.sv
// pulse_sched: timed command FIFO releasing each entry as a one-cycle strobe when qclk reaches its trigger time
//   clk, reset (async, active-low)        clocking and reset
//   qclk_val                              free-running qclk count compared against head trigger time
//   flush                                 synchronous clear of queue, late flag and drop counter
//   in_valid/in_ready/in_cmd/in_time      push side from proc
//   out_valid/out_cmd                     one-cycle release strobe and held released command
//   late_err/drop_cnt                     sticky late flag and saturating drop count
//   fifo_count                            current occupancy
module pulse_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int TIME_WIDTH = 24,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [TIME_WIDTH-1:0]   qclk_val,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_cmd,
   input  logic [TIME_WIDTH-1:0]   in_time,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   out_cmd,
   output logic                    late_err,
   output logic [7:0]              drop_cnt,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] cmd_mem [DEPTH];
   logic [TIME_WIDTH-1:0] time_mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic valid_q, valid_d, late_q, late_d;
   logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
   logic [7:0] drop_q, drop_d;
   logic [TIME_WIDTH-1:0] diff;
   logic fire, late, pop, push;
   // in_ready looks only at the registered count, so a pop at full cannot admit a push
   assign in_ready = cnt_q < (AW+1)'(DEPTH);
   assign push = in_valid && in_ready;
   // modular difference: zero fires, negative (MSB set) means the time has passed
   assign diff = time_mem[rd_q] - qclk_val;
   assign fire = (cnt_q != '0) && (diff == '0);
   assign late = (cnt_q != '0) && diff[TIME_WIDTH-1];
   assign pop = fire || late;
   always_comb begin
      wr_d    = flush ? '0 : wr_q + AW'(push);
      rd_d    = flush ? '0 : rd_q + AW'(pop);
      cnt_d   = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      valid_d = !flush && fire;
      cmd_d   = (!flush && fire) ? cmd_mem[rd_q] : cmd_q;
      late_d  = !flush && (late_q || late);
      drop_d  = flush ? '0 : drop_q + 8'(late && (drop_q != 8'hFF));
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         cmd_q   <= '0;
         late_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         cmd_q   <= cmd_d;
         late_q  <= late_d;
         drop_q  <= drop_d;
      end
   end
   // payload storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         cmd_mem[wr_q]  <= in_cmd;
         time_mem[wr_q] <= in_time;
      end
   end
   assign out_valid  = valid_q;
   assign out_cmd    = cmd_q;
   assign late_err   = late_q;
   assign drop_cnt   = drop_q;
   assign fifo_count = cnt_q;
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed and randomized checks of pulse_sched against a queue-based reference model
module tb_pulse_sched;
   localparam int DW = 32;
   localparam int TW = 24;
   localparam int D  = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready, out_valid, late_err;
   logic [TW-1:0] qclk_val = '0;
   logic [TW-1:0] in_time = '0;
   logic [DW-1:0] in_cmd = '0;
   logic [DW-1:0] out_cmd;
   logic [7:0] drop_cnt;
   logic [2:0] fifo_count;
   int tests = 0;
   int fails = 0;
   logic [DW-1:0] mq_cmd [$];
   logic [TW-1:0] mq_time [$];
   logic e_valid = 1'b0;
   logic e_late = 1'b0;
   logic [DW-1:0] e_cmd = '0;
   int e_drop = 0;
   bit acc;
   always #5 clk = ~clk;
   pulse_sched #(.DATA_WIDTH(DW), .TIME_WIDTH(TW), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .qclk_val(qclk_val), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_time(in_time),
      .out_valid(out_valid), .out_cmd(out_cmd), .late_err(late_err),
      .drop_cnt(drop_cnt), .fifo_count(fifo_count)
   );
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_cmd", out_cmd, e_cmd);
      chk("late_err", 32'(late_err), 32'(e_late));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      chk("fifo_count", 32'(fifo_count), 32'(mq_cmd.size()));
      chk("in_ready", 32'(in_ready), 32'(mq_cmd.size() < D));
   endtask
   task automatic model_clear();
      mq_cmd.delete();
      mq_time.delete();
      e_valid = 1'b0;
      e_late = 1'b0;
      e_cmd = '0;
      e_drop = 0;
   endtask
   // one clock edge of the scheduling rules, evaluated on the pre-edge inputs
   task automatic model_edge();
      logic [TW-1:0] d;
      bit full;
      acc = 1'b0;
      full = (mq_cmd.size() == D);
      e_valid = 1'b0;
      if (!reset) begin
         model_clear();
      end else if (flush) begin
         mq_cmd.delete();
         mq_time.delete();
         e_late = 1'b0;
         e_drop = 0;
      end else begin
         if (mq_cmd.size() != 0) begin
            d = mq_time[0] - qclk_val;
            if (d == '0) begin
               e_valid = 1'b1;
               e_cmd = mq_cmd[0];
               void'(mq_cmd.pop_front());
               void'(mq_time.pop_front());
            end else if (d[TW-1]) begin
               void'(mq_cmd.pop_front());
               void'(mq_time.pop_front());
               e_late = 1'b1;
               if (e_drop < 255) e_drop++;
            end
         end
         if (in_valid && !full) begin
            mq_cmd.push_back(in_cmd);
            mq_time.push_back(in_time);
            acc = 1'b1;
         end
      end
   endtask
   task automatic step(bit v, logic [DW-1:0] c, logic [TW-1:0] t, bit f = 1'b0);
      in_valid = v;
      in_cmd = c;
      in_time = t;
      flush = f;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      qclk_val = qclk_val + 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
   endtask
   task automatic idle(int n);
      repeat (n) step(1'b0, '0, '0);
   endtask
   task automatic push_wait(logic [DW-1:0] c, logic [TW-1:0] t);
      int n = 0;
      do begin
         step(1'b1, c, t);
         n++;
      end while (!acc && n < 200);
      chk("push_accept", 32'(acc), 32'd1);
   endtask
   initial begin
      #2 reset = 1'b0;
      #1 check_all();
      idle(2);
      reset = 1'b1;
      idle(1);
      // single entry released when qclk reaches 100
      qclk_val = 24'd50;
      push_wait(32'hA5, 24'd100);
      idle(55);
      // back-to-back consecutive times
      qclk_val = 24'd180;
      push_wait(32'd1, 24'd200);
      push_wait(32'd2, 24'd201);
      push_wait(32'd3, 24'd202);
      idle(25);
      // fill to full, fifth entry waits for the first release
      qclk_val = 24'd300;
      for (int i = 0; i < D; i++) push_wait(32'(10 + i), 24'(400 + i));
      chk("full_ready", 32'(in_ready), 32'd0);
      push_wait(32'd14, 24'd404);
      idle(10);
      // late entry dropped, following entry still fires
      qclk_val = 24'd40;
      step(1'b1, 32'd20, 24'd10);
      step(1'b1, 32'd21, 24'd60);
      idle(25);
      // trigger time across the qclk wrap
      qclk_val = 24'hFFFFFD;
      step(1'b1, 32'd30, 24'd2);
      idle(8);
      // flush with a same-cycle push
      qclk_val = 24'd500;
      step(1'b1, 32'd39, 24'd400);
      step(1'b1, 32'd41, 24'd600);
      step(1'b1, 32'd42, 24'd601);
      step(1'b1, 32'd43, 24'd602);
      step(1'b1, 32'd44, 24'd700, 1'b1);
      idle(5);
      // randomized traffic near the current time
      repeat (400) begin
         step(1'($urandom_range(0, 1)), $urandom, qclk_val + 24'($urandom_range(0, 20)) - 24'd3,
              $urandom_range(0, 60) == 0);
         if ($urandom_range(0, 7) == 0) qclk_val = qclk_val + 24'($urandom_range(0, 2)) - 24'd1;
      end
      idle(30);
      // drop counter saturation
      repeat (262) step(1'b1, $urandom, qclk_val - 24'd5);
      idle(3);
      // asynchronous reset in the middle of a queue
      qclk_val = 24'd1000;
      step(1'b1, 32'd50, 24'd1100);
      step(1'b1, 32'd51, 24'd1101);
      step(1'b1, 32'd52, 24'd1102);
      #2 reset = 1'b0;
      model_clear();
      #1 check_all();
      idle(2);
      reset = 1'b1;
      idle(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
